// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Drives the address stream of a synchronous instruction ROM (one-cycle read
// latency). Returned words go into a 2-entry queue and are handed to decode
// over a valid/ready handshake together with the PC they were fetched from.
// Handles decode backpressure, halt, and redirect (branch/jump). A redirect
// squashes the read in flight and flushes the queue.
//
// Ports:
//   clk             sole clock, rising edge
//   rst_n           asynchronous active-low reset
//   rom_en          ROM read strobe; one read is issued in every cycle it is 1
//   rom_addr        ROM address (always the current fetch PC)
//   rom_data        ROM output, valid the cycle after a read is issued
//   redirect_valid  one-cycle pulse: flush and restart fetch at redirect_pc
//   redirect_pc     new fetch address
//   halt            level; while 1 no new reads are issued
//   out_valid       out_instr / out_pc hold a valid instruction
//   out_ready       decode accepts the head word this cycle
//   out_instr       instruction at the queue head (registered)
//   out_pc          fetch address of out_instr (registered)
//   busy            a read is in flight or the queue is non-empty
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              busy
);

    localparam int DEPTH = 2;

    // Fetch address and the single outstanding ROM read
    logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic              inflight_reg, inflight_next;
    logic [ADDR_W-1:0] inflight_pc_reg, inflight_pc_next;

    // Shift-style queue: slot 0 is always the head, so the head registers
    // drive out_instr/out_pc directly with no output mux.
    logic [1:0]        occ_reg, occ_next;
    logic [31:0]       slot_instr_reg  [DEPTH];
    logic [31:0]       slot_instr_next [DEPTH];
    logic [ADDR_W-1:0] slot_pc_reg     [DEPTH];
    logic [ADDR_W-1:0] slot_pc_next    [DEPTH];

    logic       pop;
    logic       push;
    logic       issue;
    logic [2:0] credit_used;
    logic [2:0] credit_limit;
    logic [1:0] base_cnt;

    assign pop  = (occ_reg != 2'd0) && out_ready;
    // A read in flight during a redirect cycle belongs to the old path: drop it.
    assign push = inflight_reg && !redirect_valid;

    // Credit rule: every queued word plus the read in flight owns one slot;
    // a head leaving this cycle frees its slot immediately, so a full-rate
    // stream never bubbles.
    assign credit_used  = {1'b0, occ_reg} + {2'b00, inflight_reg};
    assign credit_limit = 3'd2 + {2'b00, pop};
    // rst_n gating keeps the strobe low while reset is held.
    assign issue = rst_n && !halt && !redirect_valid && (credit_used < credit_limit);

    // Occupancy after the pop, i.e. the slot index a push lands in.
    assign base_cnt = occ_reg - {1'b0, pop};

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        inflight_next    = issue;
        inflight_pc_next = inflight_pc_reg;
        occ_next         = base_cnt + {1'b0, push};

        if (issue) begin
            fetch_pc_next    = fetch_pc_reg + PC_STEP;
            inflight_pc_next = fetch_pc_reg;
        end

        // A head handshake in the redirect cycle still completes (pop above);
        // whatever remains is discarded.
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc;
            occ_next      = 2'd0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic              push_here;
            logic              shift_here;
            logic [31:0]       up_instr;
            logic [ADDR_W-1:0] up_pc;

            if (gi < DEPTH - 1) begin : g_up
                assign up_instr = slot_instr_reg[gi + 1];
                assign up_pc    = slot_pc_reg[gi + 1];
            end else begin : g_top
                assign up_instr = '0;
                assign up_pc    = '0;
            end

            assign push_here  = push && (base_cnt == 2'(gi));
            assign shift_here = pop && (occ_reg > 2'(gi + 1));

            assign slot_instr_next[gi] = push_here  ? rom_data :
                                         shift_here ? up_instr : slot_instr_reg[gi];
            assign slot_pc_next[gi]    = push_here  ? inflight_pc_reg :
                                         shift_here ? up_pc : slot_pc_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            occ_reg         <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_instr_reg[i] <= '0;
                slot_pc_reg[i]    <= '0;
            end
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            inflight_reg    <= inflight_next;
            inflight_pc_reg <= inflight_pc_next;
            occ_reg         <= occ_next;
            for (int i = 0; i < DEPTH; i++) begin
                slot_instr_reg[i] <= slot_instr_next[i];
                slot_pc_reg[i]    <= slot_pc_next[i];
            end
        end
    end

    assign rom_en    = issue;
    assign rom_addr  = fetch_pc_reg;
    assign out_valid = (occ_reg != 2'd0);
    assign out_instr = slot_instr_reg[0];
    assign out_pc    = slot_pc_reg[0];
    assign busy      = inflight_reg || (occ_reg != 2'd0);

    // The credit rule makes a push into a full queue unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (occ_reg == 2'(DEPTH))));

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Scenario tasks for fetch_sequencer run against a reference model that keeps
// the reads as a plain queue of {pc, issue cycle}. A word is visible to decode
// two cycles after its read, a redirect forgets every read not consumed, and
// the queue length (reads issued but not yet consumed) may never exceed two.
// ROM contents: ROM[a] = 0xA000_0000 + a.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] PC_STEP  = 32'h1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_en         (rom_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Synchronous ROM, one-cycle latency
    always @(posedge clk) begin
        if (rom_en) rom_data <= 32'hA000_0000 + rom_addr;
    end

    // ---------------- reference model ----------------
    logic [31:0] q_pc [$];
    int          q_t  [$];
    int          cyc;
    logic [31:0] exp_issue_pc;
    logic        exp_valid, exp_pop, exp_rom_en, exp_busy;
    logic [31:0] exp_pc, exp_instr;

    function automatic void model_eval();
        exp_valid  = (q_pc.size() != 0) && (q_t[0] + 2 <= cyc);
        exp_pc     = exp_valid ? q_pc[0] : 32'h0;
        exp_instr  = 32'hA000_0000 + exp_pc;
        exp_pop    = exp_valid && out_ready;
        exp_busy   = (q_pc.size() != 0);
        exp_rom_en = rst_n && !halt && !redirect_valid &&
                     ((q_pc.size() - (exp_pop ? 1 : 0)) < 2);
    endfunction

    initial begin
        cyc = 0;
        exp_issue_pc = RESET_PC;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q_pc.delete();
                q_t.delete();
                exp_issue_pc = RESET_PC;
            end else begin
                model_eval();
                if (exp_pop) begin
                    void'(q_pc.pop_front());
                    void'(q_t.pop_front());
                end
                if (redirect_valid) begin
                    q_pc.delete();
                    q_t.delete();
                end
                if (exp_rom_en) begin
                    q_pc.push_back(exp_issue_pc);
                    q_t.push_back(cyc);
                end
                if (redirect_valid) exp_issue_pc = redirect_pc;
                else if (exp_rom_en) exp_issue_pc = exp_issue_pc + PC_STEP;
                cyc++;
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1 rst_n = 1'b0;
        halt = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rom_en, rom_addr, out_valid, out_instr, out_pc, busy} !==
            {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got en=%b addr=%h v=%b instr=%h pc=%h busy=%b exp 0/%h/0/0/0/0",
                     rom_en, rom_addr, out_valid, out_instr, out_pc, busy, RESET_PC);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        int first_valid = -1;
        int nvalid = 0;
        halt = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); model_eval();
            checks++; if ({rom_en, rom_addr} !== {exp_rom_en, exp_issue_pc}) begin errors++;
                $display("FAIL stream_fetch cyc %0d got %b/%h exp %b/%h", cyc, rom_en, rom_addr, exp_rom_en, exp_issue_pc); end
            checks++; if ({out_valid, busy} !== {exp_valid, exp_busy}) begin errors++;
                $display("FAIL stream_status cyc %0d valid/busy got %b/%b exp %b/%b", cyc, out_valid, busy, exp_valid, exp_busy); end
            if (exp_valid) begin checks++; if ({out_pc, out_instr} !== {exp_pc, exp_instr}) begin errors++;
                $display("FAIL stream_word cyc %0d got %h/%h exp %h/%h", cyc, out_pc, out_instr, exp_pc, exp_instr); end end
            if (out_valid && first_valid < 0) first_valid = i;
            if (out_valid) nvalid++;
            @(posedge clk); #1;
        end
        checks++; if (first_valid != 2) begin errors++;
            $display("FAIL stream_latency first out_valid at %0d exp 2", first_valid); end
        checks++; if (nvalid != 10) begin errors++;
            $display("FAIL stream_throughput valid cycles %0d exp 10", nvalid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] held_pc = 32'h0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); model_eval();
            if (i == 0) held_pc = exp_pc;
            checks++; if ({rom_en, rom_addr} !== {exp_rom_en, exp_issue_pc}) begin errors++;
                $display("FAIL bp_fetch cyc %0d got %b/%h exp %b/%h", cyc, rom_en, rom_addr, exp_rom_en, exp_issue_pc); end
            checks++; if ({out_valid, busy} !== {exp_valid, exp_busy}) begin errors++;
                $display("FAIL bp_status cyc %0d valid/busy got %b/%b exp %b/%b", cyc, out_valid, busy, exp_valid, exp_busy); end
            if (exp_valid) begin checks++; if ({out_pc, out_instr} !== {exp_pc, exp_instr}) begin errors++;
                $display("FAIL bp_word cyc %0d got %h/%h exp %h/%h", cyc, out_pc, out_instr, exp_pc, exp_instr); end end
            if (i == 4) begin
                checks++; if ({rom_en, out_valid, out_pc} !== {1'b0, 1'b1, held_pc}) begin errors++;
                    $display("FAIL bp_hold got en=%b v=%b pc=%h exp 0/1/%h", rom_en, out_valid, out_pc, held_pc); end
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); model_eval();
            checks++; if ({rom_en, rom_addr} !== {exp_rom_en, exp_issue_pc}) begin errors++;
                $display("FAIL bp_rel_fetch cyc %0d got %b/%h exp %b/%h", cyc, rom_en, rom_addr, exp_rom_en, exp_issue_pc); end
            checks++; if ({out_valid, busy} !== {exp_valid, exp_busy}) begin errors++;
                $display("FAIL bp_rel_status cyc %0d valid/busy got %b/%b exp %b/%b", cyc, out_valid, busy, exp_valid, exp_busy); end
            if (exp_valid) begin checks++; if ({out_pc, out_instr} !== {exp_pc, exp_instr}) begin errors++;
                $display("FAIL bp_rel_word cyc %0d got %h/%h exp %h/%h", cyc, out_pc, out_instr, exp_pc, exp_instr); end end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        int got_at = -1;
        out_ready = 1'b1; halt = 1'b0;
        for (int i = 0; i < 7; i++) begin
            redirect_valid = (i == 0);
            redirect_pc    = 32'h40;
            @(negedge clk); model_eval();
            checks++; if ({rom_en, rom_addr} !== {exp_rom_en, exp_issue_pc}) begin errors++;
                $display("FAIL redir_fetch cyc %0d got %b/%h exp %b/%h", cyc, rom_en, rom_addr, exp_rom_en, exp_issue_pc); end
            checks++; if ({out_valid, busy} !== {exp_valid, exp_busy}) begin errors++;
                $display("FAIL redir_status cyc %0d valid/busy got %b/%b exp %b/%b", cyc, out_valid, busy, exp_valid, exp_busy); end
            if (exp_valid) begin checks++; if ({out_pc, out_instr} !== {exp_pc, exp_instr}) begin errors++;
                $display("FAIL redir_word cyc %0d got %h/%h exp %h/%h", cyc, out_pc, out_instr, exp_pc, exp_instr); end end
            if (i > 0 && got_at < 0 && out_valid && out_pc == 32'h40) got_at = i;
            if (i == 4) begin
                checks++; if ({out_valid, out_pc} !== {1'b1, 32'h41}) begin errors++;
                    $display("FAIL redir_next got v=%b pc=%h exp 1/00000041", out_valid, out_pc); end
            end
            @(posedge clk); #1;
        end
        redirect_valid = 1'b0;
        checks++; if (got_at != 3) begin errors++;
            $display("FAIL redir_latency target delivered at %0d exp 3", got_at); end
    endtask

    task automatic test_halt();
        int en_cnt = 0;
        int deliv  = 0;
        out_ready = 1'b0; halt = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) begin halt = 1'b1; out_ready = 1'b1; end
            if (i == 7) halt = 1'b0;
            @(negedge clk); model_eval();
            checks++; if ({rom_en, rom_addr} !== {exp_rom_en, exp_issue_pc}) begin errors++;
                $display("FAIL halt_fetch cyc %0d got %b/%h exp %b/%h", cyc, rom_en, rom_addr, exp_rom_en, exp_issue_pc); end
            checks++; if ({out_valid, busy} !== {exp_valid, exp_busy}) begin errors++;
                $display("FAIL halt_status cyc %0d valid/busy got %b/%b exp %b/%b", cyc, out_valid, busy, exp_valid, exp_busy); end
            if (exp_valid) begin checks++; if ({out_pc, out_instr} !== {exp_pc, exp_instr}) begin errors++;
                $display("FAIL halt_word cyc %0d got %h/%h exp %h/%h", cyc, out_pc, out_instr, exp_pc, exp_instr); end end
            if (i >= 3 && i < 7) begin
                if (rom_en) en_cnt++;
                if (out_valid) deliv++;
            end
            if (i == 6) begin
                checks++; if (busy !== 1'b0) begin errors++;
                    $display("FAIL halt_idle busy got %b exp 0", busy); end
            end
            @(posedge clk); #1;
        end
        checks++; if (en_cnt != 0) begin errors++;
            $display("FAIL halt_no_issue rom_en cycles %0d exp 0", en_cnt); end
        checks++; if (deliv != 2) begin errors++;
            $display("FAIL halt_drain delivered %0d exp 2", deliv); end
    endtask

    task automatic test_wrap();
        logic [31:0] wpcs [$];
        out_ready = 1'b1; halt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            redirect_valid = (i == 0);
            redirect_pc    = 32'hFFFF_FFFF;
            @(negedge clk); model_eval();
            checks++; if ({rom_en, rom_addr} !== {exp_rom_en, exp_issue_pc}) begin errors++;
                $display("FAIL wrap_fetch cyc %0d got %b/%h exp %b/%h", cyc, rom_en, rom_addr, exp_rom_en, exp_issue_pc); end
            checks++; if ({out_valid, busy} !== {exp_valid, exp_busy}) begin errors++;
                $display("FAIL wrap_status cyc %0d valid/busy got %b/%b exp %b/%b", cyc, out_valid, busy, exp_valid, exp_busy); end
            if (exp_valid) begin checks++; if ({out_pc, out_instr} !== {exp_pc, exp_instr}) begin errors++;
                $display("FAIL wrap_word cyc %0d got %h/%h exp %h/%h", cyc, out_pc, out_instr, exp_pc, exp_instr); end end
            if (i > 0 && out_valid) wpcs.push_back(out_pc);
            @(posedge clk); #1;
        end
        redirect_valid = 1'b0;
        checks++;
        if (wpcs.size() < 2 || wpcs[0] !== 32'hFFFF_FFFF || wpcs[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_seq delivered %0d words first %h second %h exp ffffffff 00000000",
                     wpcs.size(), (wpcs.size() > 0) ? wpcs[0] : 32'h0, (wpcs.size() > 1) ? wpcs[1] : 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); model_eval();
            checks++; if ({out_valid, busy} !== {exp_valid, exp_busy}) begin errors++;
                $display("FAIL rstmid_fill cyc %0d valid/busy got %b/%b exp %b/%b", cyc, out_valid, busy, exp_valid, exp_busy); end
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rom_en, rom_addr, out_valid, out_instr, out_pc, busy} !==
            {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_values got en=%b addr=%h v=%b instr=%h pc=%h busy=%b exp 0/%h/0/0/0/0",
                     rom_en, rom_addr, out_valid, out_instr, out_pc, busy, RESET_PC);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); model_eval();
            checks++; if ({rom_en, rom_addr} !== {exp_rom_en, exp_issue_pc}) begin errors++;
                $display("FAIL rstmid_fetch cyc %0d got %b/%h exp %b/%h", cyc, rom_en, rom_addr, exp_rom_en, exp_issue_pc); end
            checks++; if ({out_valid, busy} !== {exp_valid, exp_busy}) begin errors++;
                $display("FAIL rstmid_status cyc %0d valid/busy got %b/%b exp %b/%b", cyc, out_valid, busy, exp_valid, exp_busy); end
            if (exp_valid) begin checks++; if ({out_pc, out_instr} !== {exp_pc, exp_instr}) begin errors++;
                $display("FAIL rstmid_word cyc %0d got %h/%h exp %h/%h", cyc, out_pc, out_instr, exp_pc, exp_instr); end end
            if (i == 0) begin
                checks++; if ({rom_en, rom_addr} !== {1'b1, RESET_PC}) begin errors++;
                    $display("FAIL rstmid_restart got %b/%h exp 1/%h", rom_en, rom_addr, RESET_PC); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        int delivered = 0;
        for (int i = 0; i < 400; i++) begin
            out_ready      = ($urandom_range(9) < 7);
            halt           = ($urandom_range(9) == 0);
            redirect_valid = ($urandom_range(19) == 0);
            redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(1))) : $urandom;
            @(negedge clk); model_eval();
            checks++; if ({rom_en, rom_addr} !== {exp_rom_en, exp_issue_pc}) begin errors++;
                $display("FAIL rand_fetch cyc %0d got %b/%h exp %b/%h", cyc, rom_en, rom_addr, exp_rom_en, exp_issue_pc); end
            checks++; if ({out_valid, busy} !== {exp_valid, exp_busy}) begin errors++;
                $display("FAIL rand_status cyc %0d valid/busy got %b/%b exp %b/%b", cyc, out_valid, busy, exp_valid, exp_busy); end
            if (exp_valid) begin checks++; if ({out_pc, out_instr} !== {exp_pc, exp_instr}) begin errors++;
                $display("FAIL rand_word cyc %0d got %h/%h exp %h/%h", cyc, out_pc, out_instr, exp_pc, exp_instr); end end
            if (out_valid && out_ready) delivered++;
            @(posedge clk); #1;
        end
        redirect_valid = 1'b0; halt = 1'b0; out_ready = 1'b1;
        checks++; if (delivered < 100) begin errors++;
            $display("FAIL rand_progress delivered %0d exp >= 100", delivered); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
